// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller.
//   CNT_W       : width of divisor and period counter
//   DEFAULT_DIV : divisor in effect after reset (>= MIN_DIV)
//   MIN_DIV     : smallest legal divisor; smaller offers are discarded
//   state_e     : controller sequencing states
package clk_div_pkg;

    localparam int CNT_W = 28;

    localparam logic [CNT_W-1:0] DEFAULT_DIV = 28'd8;
    localparam logic [CNT_W-1:0] MIN_DIV     = 28'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration channel (valid/ready) with error pulse.
//   cfg_valid   : source offers a divisor
//   cfg_divisor : offered divisor, held stable until transfer
//   cfg_ready   : controller can take a divisor this cycle
//   cfg_err     : one-cycle pulse, accepted divisor was illegal and dropped
// master = divisor source, slave = controller.
interface clk_div_ctrl_if;
    import clk_div_pkg::*;

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_divisor;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_divisor,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_divisor,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Period counter, wrap decode and registered divided output.
//   clk_i     : system clock
//   clr_i     : synchronous clear (counter and output to 0)
//   en_i      : count this cycle (controller busy)
//   div_i     : divisor in effect
//   wrap_o    : last cycle of the period (counter == div-1 while enabled)
//   clk_out_o : low for floor(div/2) cycles, then high for the rest
module clk_div_core
    import clk_div_pkg::*;
(
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             wrap_o,
    output logic             clk_out_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clk_out_q, clk_out_d;

    assign wrap_o    = en_i & (cnt_q == (div_i - ONE));
    assign clk_out_o = clk_out_q;

    // The divisor only changes on a wrap (or while idle), and the counter is
    // 0 after either, so the output for the next cycle can be derived from the
    // current divisor. A restarted period always begins low because div >= 2.
    always_comb begin
        cnt_inc   = cnt_q + ONE;
        cnt_d     = cnt_q;
        clk_out_d = 1'b0;
        if (en_i) begin
            if (wrap_o) begin
                cnt_d = '0;
            end else begin
                cnt_d     = cnt_inc;
                clk_out_d = (cnt_inc >= (div_i >> 1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the counter-based clock divider: start/stop
// sequencing, one-deep divisor buffer applied only at period boundaries,
// and a per-period tick.
//   clk_in     : system clock (posedge)
//   rst        : synchronous active-high reset
//   run        : 1 = produce output, 0 = stop after the current period
//   cfg        : divisor configuration channel (slave side)
//   busy       : controller in RUN or STOP
//   tick       : one-cycle pulse on the last cycle of each output period
//   clk_out    : divided output
//   active_div : divisor currently in effect
//
// state | meaning
// IDLE  | counter held at 0, clk_out low, pending divisor applied at once
// RUN   | counting periods
// STOP  | counting, returns to IDLE at the end of the current period
module clk_div_ctrl
    import clk_div_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  run,
    clk_div_ctrl_if.slave         cfg,
    output logic                  busy,
    output logic                  tick,
    output logic                  clk_out,
    output logic [CNT_W-1:0]      active_div
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q, cfg_err_d;

    logic             busy_w;
    logic             wrap_w;
    logic             xfer_w;

    assign busy_w = (state_q != IDLE);
    assign xfer_w = cfg.cfg_valid & ~pend_vld_q;

    clk_div_core u_core (
        .clk_i     (clk_in),
        .clr_i     (rst),
        .en_i      (busy_w),
        .div_i     (active_div_q),
        .wrap_o    (wrap_w),
        .clk_out_o (clk_out)
    );

    always_comb begin
        state_d      = state_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_vld_d   = pend_vld_q;
        cfg_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Applying here means a simultaneous run=1 starts with the
                // new divisor on its very first period.
                if (pend_vld_q) begin
                    active_div_d = pend_div_q;
                    pend_vld_d   = 1'b0;
                end
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (run) begin
                    state_d = RUN;
                end else if (wrap_w) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (busy_w && wrap_w && pend_vld_q) begin
            active_div_d = pend_div_q;
            pend_vld_d   = 1'b0;
        end

        // A transfer only happens with the buffer empty, so it never collides
        // with the apply paths above; a value taken on a wrap waits one period.
        if (xfer_w) begin
            if (cfg.cfg_divisor < MIN_DIV) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_div_d = cfg.cfg_divisor;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            active_div_q <= DEFAULT_DIV;
            pend_div_q   <= '0;
            pend_vld_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_vld_q   <= pend_vld_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign busy          = busy_w;
    assign tick          = wrap_w;
    assign active_div    = active_div_q;
    assign cfg.cfg_ready = ~pend_vld_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    logic             clk_in;
    logic             rst;
    logic             run;
    logic             busy;
    logic             tick;
    logic             clk_out;
    logic [CNT_W-1:0] active_div;

    clk_div_ctrl_if cfg_if ();

    clk_div_ctrl dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .run        (run),
        .cfg        (cfg_if),
        .busy       (busy),
        .tick       (tick),
        .clk_out    (clk_out),
        .active_div (active_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a running flag, a position within the period,
    // the divisor in effect and a one-entry queue of accepted divisors.
    bit m_running  = 0;
    bit m_stopping = 0;
    int m_pos      = 0;
    int m_div      = 8;
    int m_pend[$];
    bit m_err      = 0;
    bit m_last_xfer = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_update();
        bit xfer;
        if (rst) begin
            m_running   = 0;
            m_stopping  = 0;
            m_pos       = 0;
            m_div       = 8;
            m_pend.delete();
            m_err       = 0;
            m_last_xfer = 0;
            return;
        end
        xfer        = cfg_if.cfg_valid && (m_pend.size() == 0);
        m_last_xfer = xfer;
        m_err       = 0;
        if (m_running) begin
            if (m_pos == m_div - 1) begin
                m_pos = 0;
                if (m_pend.size() > 0) m_div = m_pend.pop_front();
                if (m_stopping && !run) m_running = 0;
            end else begin
                m_pos++;
            end
            m_stopping = m_running && !run;
        end else begin
            if (m_pend.size() > 0) m_div = m_pend.pop_front();
            if (run) begin
                m_running  = 1;
                m_pos      = 0;
                m_stopping = 0;
            end
        end
        if (xfer) begin
            if (cfg_if.cfg_divisor < 2) m_err = 1;
            else m_pend.push_back(int'(cfg_if.cfg_divisor));
        end
    endfunction

    task automatic compare_all();
        chk("busy",       {31'd0, busy},       {31'd0, m_running});
        chk("tick",       {31'd0, tick},       {31'd0, m_running && (m_pos == m_div - 1)});
        chk("clk_out",    {31'd0, clk_out},    {31'd0, m_running && (m_pos >= m_div / 2)});
        chk("cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, m_pend.size() == 0});
        chk("cfg_err",    {31'd0, cfg_if.cfg_err},   {31'd0, m_err});
        chk("active_div", {4'd0, active_div},  m_div);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(m_running && m_pos == p) && n < 40) begin
            cyc();
            n++;
        end
        chk("wait_pos_reached", m_pos, p);
    endtask

    task automatic send_cfg(input int d);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_divisor = CNT_W'(d);
        cyc();
        cfg_if.cfg_valid   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nt, nh, n;
        rst = 1'b1;
        run = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_divisor = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_active_div", {4'd0, active_div}, 32'd8);
        chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clk_out", {31'd0, clk_out}, 32'd0);

        // Default divisor 8: 16 cycles -> 2 ticks, 8 high cycles.
        run = 1'b1;
        nt = 0; nh = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (tick) nt++;
            if (clk_out) nh++;
            if (i == 7) chk("first_tick_at_8th", {31'd0, tick}, 32'd1);
            if (i == 3) chk("low_before_half", {31'd0, clk_out}, 32'd0);
            if (i == 4) chk("high_from_half", {31'd0, clk_out}, 32'd1);
        end
        chk("div8_ticks", nt, 2);
        chk("div8_high", nh, 8);

        // Illegal divisors 1 then 0 back to back.
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_divisor = 28'd1;
        cyc();
        chk("err_div1", {31'd0, cfg_if.cfg_err}, 32'd1);
        cfg_if.cfg_divisor = 28'd0;
        cyc();
        chk("err_div0", {31'd0, cfg_if.cfg_err}, 32'd1);
        cfg_if.cfg_valid = 1'b0;
        cyc();
        chk("err_cleared", {31'd0, cfg_if.cfg_err}, 32'd0);
        chk("err_keeps_div", {4'd0, active_div}, 32'd8);
        chk("err_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

        // Stop at counter 3, cancel at counter 5, then stop for real.
        wait_pos(3);
        run = 1'b0;
        cyc();
        cyc();
        run = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!busy) n++;
        end
        chk("stop_cancel_no_gap", n, 0);
        wait_pos(3);
        run = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk("stop_to_idle_busy", {31'd0, busy}, 32'd0);
        chk("stop_to_idle_clk", {31'd0, clk_out}, 32'd0);
        chk("stop_to_idle_cycles", n, 5);

        // Load 5 in IDLE, then run: 10 cycles -> 2 ticks, 6 high.
        send_cfg(5);
        cyc();
        chk("idle_load5", {4'd0, active_div}, 32'd5);
        run = 1'b1;
        nt = 0; nh = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick) nt++;
            if (clk_out) nh++;
        end
        chk("div5_ticks", nt, 2);
        chk("div5_high", nh, 6);

        // Pending divisor then reset mid-period: pending must vanish.
        wait_pos(0);
        send_cfg(7);
        chk("pend_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
        wait_pos(3);
        rst = 1'b1;
        run = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_tick", {31'd0, tick}, 32'd0);
        chk("rst_mid_clk", {31'd0, clk_out}, 32'd0);
        chk("rst_mid_div", {4'd0, active_div}, 32'd8);
        chk("rst_mid_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        cyc(); cyc(); cyc();
        chk("rst_pend_dropped", {4'd0, active_div}, 32'd8);

        // Running at 8, divisor 4 offered at counter 2.
        run = 1'b1;
        wait_pos(2);
        send_cfg(4);
        for (int i = 0; i < 20; i++) cyc();
        chk("mid_cfg_applied", {4'd0, active_div}, 32'd4);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            rst = ($urandom_range(0, 299) == 0);
            if (!(cfg_if.cfg_valid && !m_last_xfer)) begin
                cfg_if.cfg_valid   = ($urandom_range(0, 9) == 0);
                cfg_if.cfg_divisor = CNT_W'($urandom_range(0, 12));
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
